// File: rtl/comms_pkg.sv
// Shared opcodes, default bit timing and state types for the UART command/storage block.
package comms_pkg;

  localparam logic [7:0] OP_WRITE_ALL = 8'h00;
  localparam logic [7:0] OP_READ      = 8'h04;

  // 4 Mbaud from a 100 MHz clock.
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 25;

  typedef enum logic [2:0] {
    StIdle,
    StHdr1,
    StHdr2,
    StWrite,
    StRead
  } ctrl_state_e;

  typedef enum logic [1:0] {
    TxStart,
    TxData,
    TxStop
  } tx_phase_e;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop,
    RxBreak
  } rx_state_e;

  // Index width for a range of n values, never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle byte_valid strobe.
module uart_rx
  import comms_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rxd_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o
);

  localparam int unsigned     CntW     = idx_width(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

  logic            rx_meta_q;
  logic            rx_sync_q;
  rx_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic [7:0]      byte_q;
  logic            valid_q;

  // Line idles high, so the synchronizer resets to 1 to avoid a phantom start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rxd_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RxIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        RxIdle: begin
          if (!rx_sync_q) begin
            cnt_q   <= '0;
            state_q <= RxStart;
          end
        end
        RxStart: begin
          if (cnt_q == HalfLast) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rx_sync_q ? RxIdle : RxData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxData: begin
          if (cnt_q == BitLast) begin
            cnt_q   <= '0;
            shift_q <= {rx_sync_q, shift_q[7:1]};
            if (bit_q == 3'd7) begin
              state_q <= RxStop;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxStop: begin
          if (cnt_q == BitLast) begin
            cnt_q <= '0;
            if (rx_sync_q) begin
              byte_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= RxIdle;
            end else begin
              state_q <= RxBreak;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // After a framing error, wait for the line to go high before hunting a new start.
        RxBreak: begin
          if (rx_sync_q) begin
            state_q <= RxIdle;
          end
        end
        default: state_q <= RxIdle;
      endcase
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;

endmodule

// File: rtl/top_level.sv
// UART-driven word store: 3-byte header commands write all words or read one word back
// as back-to-back 8N1 frames.
module top_level
  import comms_pkg::*;
#(
  parameter int unsigned DATA_ADDRS   = 2,
  parameter int unsigned WORD_BYTES   = 128,
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk_100mhz,
  input  logic sys_rst,
  input  logic uart_rxd,
  output logic uart_txd
);

  localparam int unsigned      WordBits = WORD_BYTES * 8;
  localparam int unsigned      AddrW    = idx_width(DATA_ADDRS);
  localparam int unsigned      ByteW    = idx_width(WORD_BYTES);
  localparam int unsigned      CntW     = idx_width(CLKS_PER_BIT);
  localparam logic [CntW-1:0]  BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [ByteW-1:0] ByteLast = ByteW'(WORD_BYTES - 1);
  localparam logic [AddrW-1:0] AddrLast = AddrW'(DATA_ADDRS - 1);

  logic [7:0] rx_byte;
  logic       rx_valid;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx (
    .clk_i       (clk_100mhz),
    .rst_ni      (sys_rst),
    .rxd_i       (uart_rxd),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid)
  );

  logic [WordBits-1:0] mem_q [DATA_ADDRS];

  ctrl_state_e      state_q;
  logic [7:0]       opcode_q;
  logic [AddrW-1:0] wr_word_q;
  logic [ByteW-1:0] wr_byte_q;
  logic [AddrW-1:0] rd_word_q;
  logic [ByteW-1:0] tx_byte_q;
  tx_phase_e        tx_phase_q;
  logic [CntW-1:0]  tx_cnt_q;
  logic [2:0]       tx_bit_q;
  logic [7:0]       tx_shift_q;
  logic             txd_q;

  logic             mem_we;
  logic [ByteW-1:0] tx_byte_nxt;
  logic [7:0]       tx_next_data;

  always_comb begin
    mem_we       = (state_q == StWrite) && rx_valid;
    tx_byte_nxt  = tx_byte_q + 1'b1;
    tx_next_data = mem_q[rd_word_q][{tx_byte_nxt, 3'b000} +: 8];
  end

  always_ff @(posedge clk_100mhz or negedge sys_rst) begin
    if (!sys_rst) begin
      for (int i = 0; i < DATA_ADDRS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[wr_word_q][{wr_byte_q, 3'b000} +: 8] <= rx_byte;
    end
  end

  // Control FSM; the transmitter runs inside StRead so reply bytes chain without gaps.
  always_ff @(posedge clk_100mhz or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q    <= StIdle;
      opcode_q   <= '0;
      wr_word_q  <= '0;
      wr_byte_q  <= '0;
      rd_word_q  <= '0;
      tx_byte_q  <= '0;
      tx_phase_q <= TxStart;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rx_valid) begin
            opcode_q <= rx_byte;
            state_q  <= StHdr1;
          end
        end
        StHdr1: begin
          if (rx_valid) begin
            rd_word_q <= AddrW'(32'(rx_byte) % DATA_ADDRS);
            state_q   <= StHdr2;
          end
        end
        StHdr2: begin
          if (rx_valid) begin
            if (opcode_q == OP_WRITE_ALL) begin
              wr_word_q <= '0;
              wr_byte_q <= '0;
              state_q   <= StWrite;
            end else if (opcode_q == OP_READ) begin
              tx_byte_q  <= '0;
              tx_phase_q <= TxStart;
              tx_cnt_q   <= '0;
              tx_shift_q <= mem_q[rd_word_q][7:0];
              txd_q      <= 1'b0;
              state_q    <= StRead;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StWrite: begin
          if (rx_valid) begin
            if (wr_byte_q == ByteLast) begin
              wr_byte_q <= '0;
              if (wr_word_q == AddrLast) begin
                state_q <= StIdle;
              end else begin
                wr_word_q <= wr_word_q + 1'b1;
              end
            end else begin
              wr_byte_q <= wr_byte_q + 1'b1;
            end
          end
        end
        StRead: begin
          if (tx_cnt_q != BitLast) begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end else begin
            tx_cnt_q <= '0;
            unique case (tx_phase_q)
              TxStart: begin
                tx_phase_q <= TxData;
                tx_bit_q   <= '0;
                txd_q      <= tx_shift_q[0];
              end
              TxData: begin
                if (tx_bit_q == 3'd7) begin
                  tx_phase_q <= TxStop;
                  txd_q      <= 1'b1;
                end else begin
                  tx_bit_q   <= tx_bit_q + 1'b1;
                  tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                  txd_q      <= tx_shift_q[1];
                end
              end
              TxStop: begin
                if (tx_byte_q == ByteLast) begin
                  state_q <= StIdle;
                end else begin
                  tx_byte_q  <= tx_byte_nxt;
                  tx_shift_q <= tx_next_data;
                  tx_phase_q <= TxStart;
                  txd_q      <= 1'b0;
                end
              end
              default: tx_phase_q <= TxStart;
            endcase
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign uart_txd = txd_q;

endmodule

// File: tb/tb_top_level.sv
// Randomized bench for top_level: drives UART commands and checks replies against a byte-array model.
module tb_top_level;

  localparam int unsigned DataAddrs = 2;
  localparam int unsigned WordBytes = 16;
  localparam int unsigned Cpb       = 8;
  localparam int unsigned Gap       = 200;
  localparam logic [7:0]  OpWrite   = 8'h00;
  localparam logic [7:0]  OpRead    = 8'h04;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rxd   = 1'b1;
  logic txd;

  top_level #(
    .DATA_ADDRS  (DataAddrs),
    .WORD_BYTES  (WordBytes),
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk_100mhz(clk),
    .sys_rst   (rst_n),
    .uart_rxd  (rxd),
    .uart_txd  (txd)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  model_mem [DataAddrs][WordBytes];
  logic [7:0]  mon_q [$];
  int unsigned mon_t [$];
  int unsigned last_stop_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Independent UART decoder on uart_txd, samples at mid-bit on falling clock edges.
  initial begin
    logic [7:0]  b;
    int unsigned t;
    forever begin
      @(negedge clk);
      if (txd === 1'b0) begin
        t = cyc;
        repeat (Cpb / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (Cpb) @(negedge clk);
          b[i] = txd;
        end
        repeat (Cpb) @(negedge clk);
        check("tx_stop_bit", {31'd0, txd}, 32'd1);
        mon_q.push_back(b);
        mon_t.push_back(t);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    rxd = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (Cpb) @(negedge clk);
    end
    last_stop_cyc = cyc;
    rxd = stop_bit;
    repeat (Cpb) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [7:0] addr);
    send_byte(op);
    send_byte(addr);
    send_byte(8'($urandom));
  endtask

  task automatic write_all();
    mon_q.delete();
    mon_t.delete();
    send_cmd(OpWrite, 8'($urandom));
    for (int w = 0; w < DataAddrs; w++) begin
      for (int k = 0; k < WordBytes; k++) begin
        send_byte(model_mem[w][k]);
      end
    end
    repeat (4 * Cpb) @(negedge clk);
    check("wr_no_tx", mon_q.size(), 0);
  endtask

  // Issue READ and compare the reply; optionally push a WRITE_ALL header mid-reply, which must be dropped.
  task automatic do_read(input logic [7:0] addr, input bit inject = 1'b0);
    int unsigned w = addr % DataAddrs;
    int unsigned budget = (WordBytes + 4) * 10 * Cpb;
    int unsigned gap;
    int unsigned n;
    int unsigned start_stop;
    mon_q.delete();
    mon_t.delete();
    send_cmd(OpRead, addr);
    start_stop = last_stop_cyc;
    if (inject) begin
      for (int i = 0; i < 3; i++) send_byte(OpWrite);
    end
    while (mon_q.size() < WordBytes && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (12 * Cpb) @(negedge clk);
    check("rd_count", mon_q.size(), WordBytes);
    if (mon_t.size() > 0) begin
      check("rd_latency", {31'd0, (mon_t[0] >= start_stop + Cpb / 2) &&
                                  (mon_t[0] <= start_stop + Cpb / 2 + 8)}, 32'd1);
    end
    n = (mon_q.size() < WordBytes) ? mon_q.size() : WordBytes;
    for (int i = 0; i < n; i++) begin
      check("rd_byte", {24'd0, mon_q[i]}, {24'd0, model_mem[w][i]});
      if (i > 0) begin
        gap = mon_t[i] - mon_t[i-1];
        check("frame_gap", {31'd0, (gap >= 10 * Cpb) && (gap <= 10 * Cpb + 2)}, 32'd1);
      end
    end
  endtask

  task automatic clear_model();
    for (int w = 0; w < DataAddrs; w++) begin
      for (int k = 0; k < WordBytes; k++) model_mem[w][k] = 8'h00;
    end
  endtask

  initial begin
    int unsigned budget;
    clear_model();
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("rst_txd", {31'd0, txd}, 32'd1);
    end
    check("rst_quiet", mon_q.size(), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    do_read(8'h00);

    // Round trip with fixed patterns, address select and wrap.
    for (int k = 0; k < WordBytes; k++) begin
      model_mem[0][k] = 8'(k);
      model_mem[1][k] = 8'(8'h80 + k);
    end
    write_all();
    do_read(8'h00);
    do_read(8'h01);
    do_read(8'h03);

    // Unknown opcode: no reply, storage untouched.
    mon_q.delete();
    mon_t.delete();
    send_cmd(8'h05, 8'h00);
    repeat (20 * Cpb) @(negedge clk);
    check("unk_quiet", mon_q.size(), 0);
    do_read(8'h00);

    // Repeated random write+read with idle gaps; one read gets bytes injected mid-reply.
    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < DataAddrs; w++) begin
        for (int k = 0; k < WordBytes; k++) model_mem[w][k] = 8'($urandom);
      end
      write_all();
      repeat (Gap) @(negedge clk);
      do_read(8'($urandom_range(0, 255)), r == 1);
      repeat (Gap) @(negedge clk);
    end
    do_read(8'h00);

    // Short low glitch, then a byte with a bad stop bit; both must be ignored.
    rxd = 1'b0;
    repeat (Cpb / 2 - 1) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * Cpb) @(negedge clk);
    send_byte(OpRead, 1'b0);
    repeat (2 * Cpb) @(negedge clk);
    do_read(8'h01);

    // Reset in the middle of a reply frame.
    mon_q.delete();
    mon_t.delete();
    send_cmd(OpRead, 8'h00);
    budget = 40 * Cpb;
    while (mon_q.size() < 2 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    budget = 12 * Cpb;
    while (txd !== 1'b0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("mid_tx_low", {31'd0, txd}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_txd", {31'd0, txd}, 32'd1);
    clear_model();
    repeat (10) @(negedge clk);
    check("mid_rst_hold", {31'd0, txd}, 32'd1);
    rst_n = 1'b1;
    repeat (12 * Cpb) @(negedge clk);
    do_read(8'h01);
    do_read(8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/top_level.md
TOP_LEVEL -- requirements
Module: top_level

Interface
REQ-001 SHALL have parameter DATA_ADDRS, default 2: number of stored data words.
REQ-002 SHALL have parameter WORD_BYTES, default 128: bytes per data word, so the word width is WORD_BYTES*8 = 1024 bits.
REQ-003 SHALL have parameter CLKS_PER_BIT, default 25: UART bit period in clocks, which gives 4 Mbaud at 100 MHz.
REQ-004 SHALL have port clk_100mhz, input, 1 bit: the single 100 MHz clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port sys_rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port uart_rxd, input, 1 bit: UART receive line, idle high.
REQ-007 SHALL have port uart_txd, output, 1 bit: UART transmit line, idle high.

Function
REQ-008 SHALL receive UART 8N1 frames, LSB first, one start bit (0), one stop bit (1).
REQ-009 SHALL pass uart_rxd through a 2-flop synchronizer before use.
REQ-010 SHALL sample each data bit at mid-bit, i.e. CLKS_PER_BIT/2 clocks after the start-bit falling edge plus n*CLKS_PER_BIT.
REQ-011 SHALL discard a byte whose start bit reads 1 at mid-bit (false start) and SHALL discard a byte whose stop bit reads 0 (framing error); neither byte is delivered.
REQ-012 SHALL hold DATA_ADDRS words of WORD_BYTES*8 bits in internal registers.
REQ-013 SHALL parse a command as 3 header bytes, H0 = opcode, H1 = address, H2 = reserved and ignored.
REQ-014 SHALL use the control FSM states IDLE -> HDR1 -> HDR2 -> (WRITE | READ) -> IDLE, advancing one state per received header byte.
REQ-015 SHALL treat opcode 0x00 as WRITE_ALL: the next DATA_ADDRS*WORD_BYTES received bytes fill words 0..DATA_ADDRS-1 in order, and H1 is ignored.
REQ-016 SHALL place the first received byte of a word in bits [7:0] and the k-th byte in bits [8k+7:8k].
REQ-017 SHALL treat opcode 0x04 as READ: transmit the WORD_BYTES bytes of word H1, bits [7:0] first, back-to-back 8N1 frames, with a new frame starting within 2 clocks of the previous stop bit ending.
REQ-018 SHALL start the READ reply within 4 clocks of the H2 stop-bit sample.
REQ-019 SHALL, when READ H1 >= DATA_ADDRS, wrap the address modulo DATA_ADDRS (with DATA_ADDRS=2, address = H1[0]).
REQ-020 SHALL, for any other opcode, return to IDLE after H2 with no storage change and no transmission.
REQ-021 SHALL discard bytes received during the READ state.
REQ-022 SHALL start parsing a new header in IDLE immediately after WRITE_ALL completes.
REQ-023 SHALL have no timeout; a partial command waits indefinitely.

Reset
REQ-024 SHALL, while sys_rst = 0, asynchronously force the FSM to IDLE, uart_txd to 1, the RX/TX bit counters and byte counters to 0, and all storage words to 0.
REQ-025 SHALL abort any in-progress reception or transmission when reset is asserted mid-operation; after release, the block waits for a fresh start bit.

Structure
REQ-026 SHALL define opcode constants (OP_WRITE_ALL = 8'h00, OP_READ = 8'h04), the FSM state enum and the default CLKS_PER_BIT in a shared package comms_pkg.
REQ-027 SHALL contain exactly one natural sub-module, uart_rx (synchronizer, bit timing, byte_valid strobe); the transmitter and FSM are implemented in top_level.

Verification
REQ-028 SHALL verify reset: hold sys_rst=0 for 10 clocks -> uart_txd=1, no activity; release, then READ 04 00 00 -> 128 bytes of 0x00.
REQ-029 SHALL verify write/read round trip: 00 00 00, then 256 bytes (word0 byte k = k, word1 byte k = 0x80+k), then 04 00 00 -> bytes 0x00..0x7F in order on uart_txd.
REQ-030 SHALL verify address select: after the round-trip write, send 04 01 00 -> bytes 0x80..0xFF; send 04 03 00 -> same as address 1 (wrap).
REQ-031 SHALL verify an unknown opcode: 05 00 00, then 04 00 00 -> only the READ reply appears, storage is unchanged, and the 0x05 command produces no output.
REQ-032 SHALL verify repeated commands: three consecutive write+read sequences with 400 us gaps -> every reply matches the last written data, and consecutive reply frames are exactly 10*CLKS_PER_BIT clocks apart (+2 max).
REQ-033 SHALL verify framing: inject a 0.5-bit glitch low, then a byte with stop bit 0 -> both are ignored, and a following valid command executes normally.
